// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the memory port arbiter.
//   - arb_state_t : arbiter FSM encodings (2-bit)
//   - owner_t     : which cache currently owns the memory port
//   - LINE_WIDTH  : bits per cache line (LINE_WORDS * WORD_SIZE)
//   - sat_inc     : saturating increment for the grant counters
package mem_port_arbiter_pkg;

  localparam int WORD_SIZE_DEF  = 16;
  localparam int LINE_WORDS_DEF = 4;
  localparam int LINE_WIDTH     = LINE_WORDS_DEF * WORD_SIZE_DEF;
  localparam int CNT_WIDTH      = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr2.sv
// Two-requester round-robin picker.
//   Clk, Reset   : clock, synchronous active-high reset
//   i_req, d_req : requests from the I-cache and D-cache
//   update       : the pick is being taken this cycle, remember it
//   grant_valid  : at least one request is present
//   grant_owner  : combinational winner (ties go to the side opposite last_grant)
//   last_grant   : registered owner of the most recent taken grant
module arb_rr2
  import mem_port_arbiter_pkg::*;
(
  input  logic   Clk,
  input  logic   Reset,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   update,
  output logic   grant_valid,
  output owner_t grant_owner,
  output owner_t last_grant
);

  owner_t last_q;

  always_comb begin
    grant_valid = i_req | d_req;
    grant_owner = OWNER_I;
    if (i_req && d_req) begin
      grant_owner = (last_q == OWNER_I) ? OWNER_D : OWNER_I;
    end else if (d_req) begin
      grant_owner = OWNER_D;
    end
  end

  // Resetting to I means the D-cache wins the very first tie.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_q <= OWNER_I;
    end else if (update && grant_valid) begin
      last_q <= grant_owner;
    end
  end

  assign last_grant = last_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between I-cache line fills and D-cache
// line fills / writebacks, one whole line per transfer.
//
// Handshake: a requester raises req with address (and, for D, d_write and
// d_wdata) and holds everything until its done pulse. Address, data and
// direction are latched at grant, so later changes are ignored. req is not
// looked at in DONE; a requester that still has req high in the IDLE cycle
// after done is granted again.
//
// Ports:
//   Clk, Reset                     clock, synchronous active-high reset
//   i_req/i_addr/i_done/i_rdata    I-cache fill interface
//   d_req/d_write/d_addr/d_wdata   D-cache request interface
//   d_done/d_rdata                 D-cache completion
//   mem_readM/mem_writeM           memory strobes, high only in BUSY
//   mem_address/mem_wdata          latched line address (bits [1:0]=0) / data
//   mem_rdata                      line returned by memory
//   grant_i_cnt/grant_d_cnt        saturating completed-grant counters
//   state_dbg/last_grant_dbg       FSM state and round-robin pointer
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int LINE_WORDS  = 4,
  parameter int MEM_LATENCY = 2
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            i_req,
  input  logic [WORD_SIZE-1:0]            i_addr,
  output logic                            i_done,
  output logic [LINE_WORDS*WORD_SIZE-1:0] i_rdata,
  input  logic                            d_req,
  input  logic                            d_write,
  input  logic [WORD_SIZE-1:0]            d_addr,
  input  logic [LINE_WORDS*WORD_SIZE-1:0] d_wdata,
  output logic                            d_done,
  output logic [LINE_WORDS*WORD_SIZE-1:0] d_rdata,
  output logic                            mem_readM,
  output logic                            mem_writeM,
  output logic [WORD_SIZE-1:0]            mem_address,
  output logic [LINE_WORDS*WORD_SIZE-1:0] mem_wdata,
  input  logic [LINE_WORDS*WORD_SIZE-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]            grant_i_cnt,
  output logic [CNT_WIDTH-1:0]            grant_d_cnt,
  output arb_state_t                      state_dbg,
  output owner_t                          last_grant_dbg
);

  localparam int LW    = LINE_WORDS * WORD_SIZE;
  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);
  localparam logic [WORD_SIZE-1:0] LINE_MASK = {{(WORD_SIZE-2){1'b1}}, 2'b00};

  arb_state_t           state_q, state_d;
  owner_t               owner_q;
  logic                 wr_q;
  logic [WORD_SIZE-1:0] addr_q;
  logic [LW-1:0]        wdata_q;
  logic [LAT_W-1:0]     lat_q;
  logic [LW-1:0]        i_rdata_q, d_rdata_q;
  logic [CNT_WIDTH-1:0] i_cnt_q, d_cnt_q;

  logic                 grant_valid;
  owner_t               grant_owner;
  logic                 grant_take;
  logic [WORD_SIZE-1:0] grant_addr;

  arb_rr2 u_rr (
    .Clk         (Clk),
    .Reset       (Reset),
    .i_req       (i_req),
    .d_req       (d_req),
    .update      (grant_take),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner),
    .last_grant  (last_grant_dbg)
  );

  assign grant_addr = ((grant_owner == OWNER_D) ? d_addr : i_addr) & LINE_MASK;

  // Next state and all FSM-derived outputs.
  always_comb begin
    state_d    = state_q;
    grant_take = 1'b0;
    mem_readM  = 1'b0;
    mem_writeM = 1'b0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          grant_take = 1'b1;
          state_d    = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        mem_readM  = ~wr_q;
        mem_writeM = wr_q;
        if (lat_q == '0) begin
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: begin
        i_done  = (owner_q == OWNER_I);
        d_done  = (owner_q == OWNER_D);
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWNER_I;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      lat_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_cnt_q   <= '0;
      d_cnt_q   <= '0;
    end else begin
      state_q <= state_d;

      if (grant_take) begin
        owner_q <= grant_owner;
        // I-cache only ever fills; D-cache direction comes from d_write.
        wr_q    <= (grant_owner == OWNER_D) && d_write;
        addr_q  <= grant_addr;
        wdata_q <= (grant_owner == OWNER_D) ? d_wdata : '0;
        lat_q   <= LAT_LOAD;
      end else if (state_q == ARB_BUSY && lat_q != '0) begin
        lat_q <= lat_q - 1'b1;
      end

      // Memory data is valid on the last strobe cycle; writebacks keep rdata.
      if (state_q == ARB_BUSY && lat_q == '0 && !wr_q) begin
        if (owner_q == OWNER_I) i_rdata_q <= mem_rdata;
        else                    d_rdata_q <= mem_rdata;
      end

      if (state_q == ARB_DONE) begin
        if (owner_q == OWNER_I) i_cnt_q <= sat_inc(i_cnt_q);
        else                    d_cnt_q <= sat_inc(d_cnt_q);
      end
    end
  end

  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign grant_i_cnt = i_cnt_q;
  assign grant_d_cnt = d_cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int L = 2;
  localparam logic [63:0] A  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] B  = 64'h9999_8888_7777_6666;
  localparam logic [63:0] WB = 64'hDEAD_BEEF_0000_FFFF;
  localparam logic [15:0] IA = 16'h0010;
  localparam logic [15:0] DA = 16'h0024;
  localparam int ST_I = 0, ST_B = 1, ST_D = 2;

  // ---------------- clock / reset / DUT ----------------
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_write = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0;
  logic [63:0] d_wdata = '0, mem_rdata = '0;
  logic        i_done, d_done, mem_readM, mem_writeM;
  logic [63:0] i_rdata, d_rdata, mem_wdata;
  logic [15:0] mem_address, grant_i_cnt, grant_d_cnt;
  arb_state_t  state_dbg;
  owner_t      last_grant_dbg;

  always #5 Clk = ~Clk;

  mem_port_arbiter #(.WORD_SIZE(16), .LINE_WORDS(4), .MEM_LATENCY(L)) dut (
    .Clk(Clk), .Reset(Reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_readM(mem_readM), .mem_writeM(mem_writeM), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .grant_i_cnt(grant_i_cnt), .grant_d_cnt(grant_d_cnt),
    .state_dbg(state_dbg), .last_grant_dbg(last_grant_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, ireq, dreq, dwr;
    logic [63:0] mrd;
    logic        e_rd, e_wr, e_id, e_dd;
    logic [15:0] e_addr;
    logic [1:0]  e_st;
    logic [15:0] e_ic, e_dc;
    logic [63:0] e_ird, e_drd;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(int rst, int ir, int dr, int dw, logic [63:0] mrd,
                              int rd, int wr, int id, int dd, logic [15:0] addr,
                              int st, int ic, int dc, logic [63:0] ird, logic [63:0] drd);
    vec_t v;
    v.rst = (rst != 0); v.ireq = (ir != 0); v.dreq = (dr != 0); v.dwr = (dw != 0);
    v.mrd = mrd;
    v.e_rd = (rd != 0); v.e_wr = (wr != 0); v.e_id = (id != 0); v.e_dd = (dd != 0);
    v.e_addr = addr; v.e_st = 2'(st); v.e_ic = 16'(ic); v.e_dc = 16'(dc);
    v.e_ird = ird; v.e_drd = drd;
    return v;
  endfunction

  // ---------------- reference model (transaction timeline) ----------------
  // A transfer granted at edge g owns the port for edges g..g+L+1:
  // strobes after edges g..g+L-1, done after edge g+L, count at edge g+L+1.
  bit          model_on = 0, primed = 0;
  int          m_edge, m_gedge;
  bit          m_busy, m_owner_d, m_last_d, m_wr;
  logic [15:0] m_addr;
  logic [63:0] m_wdata, m_ird, m_drd;
  int          m_ic, m_dc;
  logic        x_rd, x_wr, x_id, x_dd, x_last;
  logic [1:0]  x_st;

  task automatic model_edge();
    int p;
    if (Reset) begin
      m_busy = 0; m_last_d = 0; m_ird = '0; m_drd = '0; m_ic = 0; m_dc = 0;
    end else begin
      if (!m_busy && (i_req || d_req)) begin
        m_owner_d = (i_req && d_req) ? !m_last_d : d_req;
        m_last_d  = m_owner_d;
        m_busy    = 1;
        m_gedge   = m_edge;
        m_wr      = m_owner_d && d_write;
        m_addr    = (m_owner_d ? d_addr : i_addr) & 16'hFFFC;
        m_wdata   = d_wdata;
      end else if (m_busy) begin
        p = m_edge - m_gedge;
        if (p == L && !m_wr) begin
          if (m_owner_d) m_drd = mem_rdata; else m_ird = mem_rdata;
        end
        if (p == L + 1) begin
          if (m_owner_d) m_dc = (m_dc < 65535) ? m_dc + 1 : m_dc;
          else           m_ic = (m_ic < 65535) ? m_ic + 1 : m_ic;
          m_busy = 0;
        end
      end
    end
    p = m_edge - m_gedge;
    x_rd = m_busy && !m_wr && p < L;
    x_wr = m_busy && m_wr && p < L;
    x_id = m_busy && !m_owner_d && p == L;
    x_dd = m_busy && m_owner_d && p == L;
    x_st = !m_busy ? 2'(ST_I) : (p < L) ? 2'(ST_B) : 2'(ST_D);
    x_last = m_last_d;
    m_edge++;
  endtask

  always @(negedge Clk) begin
    if (model_on) begin
      if (primed) begin
        check("rnd_state", state_dbg, x_st);
        check("rnd_readM", mem_readM, x_rd);
        check("rnd_writeM", mem_writeM, x_wr);
        check("rnd_i_done", i_done, x_id);
        check("rnd_d_done", d_done, x_dd);
        check("rnd_last_grant", last_grant_dbg, x_last);
        check("rnd_i_cnt", grant_i_cnt, 16'(m_ic));
        check("rnd_d_cnt", grant_d_cnt, 16'(m_dc));
        check("rnd_i_rdata", i_rdata, m_ird);
        check("rnd_d_rdata", d_rdata, m_drd);
        if (x_rd || x_wr) check("rnd_address", mem_address, m_addr);
        if (x_wr) check("rnd_wdata", mem_wdata, m_wdata);
      end
      model_edge();
      primed = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic d_fill(input string tag);
    logic seen;
    seen = 0;
    @(posedge Clk); #1;
    d_req = 1; d_write = 0; d_addr = DA; mem_rdata = B;
    for (int w = 0; w < 12 && !seen; w++) begin
      @(negedge Clk);
      if (d_done) seen = 1;
    end
    check(tag, seen, 1'b1);
    @(posedge Clk); #1;
    d_req = 0;
    @(negedge Clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int got;
    vecs[0]  = mk(0,1,0,0,A, 0,0,0,0,16'h0,ST_I,0,0,64'h0,64'h0);
    vecs[1]  = mk(0,1,0,0,A, 1,0,0,0,IA,   ST_B,0,0,64'h0,64'h0);
    vecs[2]  = mk(0,1,0,0,A, 1,0,0,0,IA,   ST_B,0,0,64'h0,64'h0);
    vecs[3]  = mk(0,1,0,0,A, 0,0,1,0,16'h0,ST_D,0,0,A,64'h0);
    vecs[4]  = mk(0,0,0,0,A, 0,0,0,0,16'h0,ST_I,1,0,A,64'h0);
    vecs[5]  = mk(0,1,1,0,A, 0,0,0,0,16'h0,ST_I,1,0,A,64'h0);
    vecs[6]  = mk(0,1,1,0,A, 1,0,0,0,DA,   ST_B,1,0,A,64'h0);
    vecs[7]  = mk(0,1,1,0,A, 1,0,0,0,DA,   ST_B,1,0,A,64'h0);
    vecs[8]  = mk(0,1,1,0,A, 0,0,0,1,16'h0,ST_D,1,0,A,A);
    vecs[9]  = mk(0,1,0,0,A, 0,0,0,0,16'h0,ST_I,1,1,A,A);
    vecs[10] = mk(0,1,0,0,A, 1,0,0,0,IA,   ST_B,1,1,A,A);
    vecs[11] = mk(0,1,0,0,A, 1,0,0,0,IA,   ST_B,1,1,A,A);
    vecs[12] = mk(0,1,0,0,A, 0,0,1,0,16'h0,ST_D,1,1,A,A);
    vecs[13] = mk(0,0,1,1,B, 0,0,0,0,16'h0,ST_I,2,1,A,A);
    vecs[14] = mk(0,0,1,1,B, 0,1,0,0,DA,   ST_B,2,1,A,A);
    vecs[15] = mk(0,0,1,1,B, 0,1,0,0,DA,   ST_B,2,1,A,A);
    vecs[16] = mk(0,0,1,1,B, 0,0,0,1,16'h0,ST_D,2,1,A,A);
    vecs[17] = mk(0,0,0,0,B, 0,0,0,0,16'h0,ST_I,2,2,A,A);
    vecs[18] = mk(0,1,0,0,B, 0,0,0,0,16'h0,ST_I,2,2,A,A);
    vecs[19] = mk(1,1,0,0,B, 1,0,0,0,IA,   ST_B,2,2,A,A);
    vecs[20] = mk(0,0,0,0,B, 0,0,0,0,16'h0,ST_I,0,0,64'h0,64'h0);
    vecs[21] = mk(0,0,0,0,B, 0,0,0,0,16'h0,ST_I,0,0,64'h0,64'h0);
    vecs[22] = mk(0,0,0,0,B, 0,0,0,0,16'h0,ST_I,0,0,64'h0,64'h0);

    i_addr = 16'h0013; d_addr = DA; d_wdata = WB;
    Reset = 1;
    repeat (2) @(posedge Clk);

    for (int r = 0; r < 23; r++) begin
      @(posedge Clk); #1;
      Reset = vecs[r].rst; i_req = vecs[r].ireq; d_req = vecs[r].dreq;
      d_write = vecs[r].dwr; mem_rdata = vecs[r].mrd;
      @(negedge Clk);
      check($sformatf("vec%0d_state", r), state_dbg, vecs[r].e_st);
      check($sformatf("vec%0d_readM", r), mem_readM, vecs[r].e_rd);
      check($sformatf("vec%0d_writeM", r), mem_writeM, vecs[r].e_wr);
      check($sformatf("vec%0d_i_done", r), i_done, vecs[r].e_id);
      check($sformatf("vec%0d_d_done", r), d_done, vecs[r].e_dd);
      check($sformatf("vec%0d_i_cnt", r), grant_i_cnt, vecs[r].e_ic);
      check($sformatf("vec%0d_d_cnt", r), grant_d_cnt, vecs[r].e_dc);
      check($sformatf("vec%0d_i_rdata", r), i_rdata, vecs[r].e_ird);
      check($sformatf("vec%0d_d_rdata", r), d_rdata, vecs[r].e_drd);
      if (vecs[r].e_rd || vecs[r].e_wr)
        check($sformatf("vec%0d_address", r), mem_address, vecs[r].e_addr);
      if (vecs[r].e_wr)
        check($sformatf("vec%0d_wdata", r), mem_wdata, WB);
    end

    // Saturation: preload the D counter just below the top, then two grants.
    @(posedge Clk); #1;
    force dut.d_cnt_q = 16'hFFFE;
    @(negedge Clk);
    release dut.d_cnt_q;
    check("sat_preload", grant_d_cnt, 16'hFFFE);
    d_fill("sat_done1");
    check("sat_reach_ffff", grant_d_cnt, 16'hFFFF);
    d_fill("sat_done2");
    check("sat_hold_ffff", grant_d_cnt, 16'hFFFF);

    // Both requests held continuously: grants must alternate D,I,D,I,D,I.
    @(posedge Clk); #1; Reset = 1;
    @(posedge Clk); #1; Reset = 0; i_req = 1; d_req = 1; d_write = 0;
    i_addr = 16'h0040; d_addr = 16'h0081;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge Clk);
      check("alt_strobes_exclusive", mem_readM & mem_writeM, 1'b0);
      check("alt_dones_exclusive", i_done & d_done, 1'b0);
      if (i_done || d_done) begin
        check($sformatf("alt_order%0d_d", got), d_done, (got % 2) == 0);
        check($sformatf("alt_order%0d_i", got), i_done, (got % 2) == 1);
        got++;
      end
    end
    check("alt_grant_total", 64'(got), 64'd6);
    @(posedge Clk); #1; i_req = 0; d_req = 0;
    @(negedge Clk);
    check("alt_i_cnt", grant_i_cnt, 16'd3);
    check("alt_d_cnt", grant_d_cnt, 16'd3);

    // Randomized traffic against the timeline model.
    @(posedge Clk); #1;
    Reset = 1; m_edge = 0; m_gedge = 0; model_on = 1;
    for (int c = 0; c < 3000; c++) begin
      logic idn, ddn;
      @(negedge Clk);
      idn = i_done; ddn = d_done;
      @(posedge Clk); #1;
      Reset = ($urandom_range(0, 149) == 0);
      mem_rdata = {$urandom, $urandom};
      if (i_req && idn) i_req = 0;
      else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1; i_addr = 16'($urandom);
      end
      if (d_req && ddn) d_req = 0;
      else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_write = 1'($urandom_range(0, 1)); d_addr = 16'($urandom);
        d_wdata = {$urandom, $urandom};
      end
    end
    @(posedge Clk); #1;
    model_on = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
